// File: rtl/ssd_scan_decoder_pkg.sv
// ssd_pkg: constants shared between the 7-segment driver and this scan decoder.
//  - SEG_0..SEG_F : active-low cathode patterns {g,f,e,d,c,b,a} for hex 0-F
//  - SEG_BLANK    : all segments dark
//  - state_t      : scan-decoder FSM state encoding
package ssd_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// ssd_scan_decoder_if: display bus plus decoded read-back outputs.
//  master : drives the display bus (an, seg[, dp]), observes decoded outputs
//  slave  : the scan decoder itself
//  Signals: an (active-low anodes), seg (active-low {g,f,e,d,c,b,a}),
//  value, digit_valid, digit_err, update; with SSD_DP_EN also dp and dp_out.
interface ssd_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);

  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    update;
`ifdef SSD_DP_EN
  logic                    dp;
  logic [NUM_DIGITS-1:0]   dp_out;

  modport master (output an, seg, dp,
                  input  value, digit_valid, digit_err, update, dp_out);
  modport slave  (input  an, seg, dp,
                  output value, digit_valid, digit_err, update, dp_out);
`else
  modport master (output an, seg,
                  input  value, digit_valid, digit_err, update);
  modport slave  (input  an, seg,
                  output value, digit_valid, digit_err, update);
`endif

endinterface

// File: rtl/ssd_segment_decode.sv
// ssd_segment_decode: combinational inverse of the hex-to-segment table.
//  seg      in  7  active-low cathodes {g,f,e,d,c,b,a}
//  nibble   out 4  decoded hex value (0 when not a hex pattern)
//  is_hex   out 1  seg matches one of the 16 driver patterns
//  is_blank out 1  seg is all dark
module ssd_segment_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    nibble   = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: monitors a multiplexed active-low 7-segment bus and
// recovers the hex nibble shown on each digit.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus (slave): an/seg in; value, digit_valid, digit_err, update out
//  Optional SSD_DP_EN: adds dp input and dp_out per-digit decimal-point outputs.
// A digit is captured once per stable dwell: the synced sample {an,seg[,dp]}
// must stay identical for STABLE_CYCLES samples while exactly one anode is low.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  ssd_scan_decoder_if.slave bus
);

  localparam int                    CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]         CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam int                    IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0]   an_p0, an_p1, an_p2;
  logic [6:0]              seg_p0, seg_p1, seg_p2;
  logic [CW-1:0]           cnt_q;
  state_t                  state_q, state_d;
  logic                    changed, one_hot, capture;
  logic [NUM_DIGITS-1:0]   an_low;
  logic [IW-1:0]           dig_idx;
  logic [IW+1:0]           nib_lsb;
  logic [3:0]              nibble;
  logic                    is_hex, is_blank;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   valid_q, err_q;
  logic                    update_q;
`ifdef SSD_DP_EN
  logic                    dp_p0, dp_p1, dp_p2;
  logic [NUM_DIGITS-1:0]   dp_q;
`endif

  // Stage p0/p1: two-flop synchronizer; p2: previous synced sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p0  <= '1;
      an_p1  <= '1;
      an_p2  <= '1;
      seg_p0 <= '1;
      seg_p1 <= '1;
      seg_p2 <= '1;
`ifdef SSD_DP_EN
      dp_p0  <= 1'b1;
      dp_p1  <= 1'b1;
      dp_p2  <= 1'b1;
`endif
    end else begin
      an_p0  <= bus.an;
      an_p1  <= an_p0;
      an_p2  <= an_p1;
      seg_p0 <= bus.seg;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
`ifdef SSD_DP_EN
      dp_p0  <= bus.dp;
      dp_p1  <= dp_p0;
      dp_p2  <= dp_p1;
`endif
    end
  end

  // Any field changing counts as one change, so a simultaneous an+seg
  // transition restarts the dwell only once.
  always_comb begin
    changed = (an_p1 != an_p2) || (seg_p1 != seg_p2);
`ifdef SSD_DP_EN
    changed = changed || (dp_p1 != dp_p2);
`endif
  end

  assign an_low  = ~an_p1;
  assign one_hot = (an_low != '0) && ((an_low & (an_low - ONE)) == '0);

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_p1[i]) dig_idx = IW'(i);
    end
  end

  assign nib_lsb = {dig_idx, 2'b00};

  ssd_segment_decode u_decode (
    .seg      (seg_p1),
    .nibble   (nibble),
    .is_hex   (is_hex),
    .is_blank (is_blank)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (changed)          cnt_q <= '0;
    else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (changed) begin
      state_d = one_hot ? ST_TRACK : ST_IDLE;
    end else if (state_q == ST_TRACK && cnt_q == CNT_MAX) begin
      capture = 1'b1;
      state_d = ST_HOLD;
    end
  end

  // Output stage: per-digit registers, update pulses with the new values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      update_q <= 1'b0;
`ifdef SSD_DP_EN
      dp_q     <= '0;
`endif
    end else begin
      update_q <= capture;
      if (capture) begin
        if (is_hex) begin
          value_q[nib_lsb +: 4] <= nibble;
          valid_q[dig_idx]      <= 1'b1;
          err_q[dig_idx]        <= 1'b0;
        end else begin
          valid_q[dig_idx]      <= 1'b0;
          err_q[dig_idx]        <= ~is_blank;
        end
`ifdef SSD_DP_EN
        dp_q[dig_idx] <= ~dp_p1;
`endif
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.update      = update_q;
`ifdef SSD_DP_EN
  assign bus.dp_out      = dp_q;
`endif

endmodule
